// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon-AEAD128 types and constants: S-box tables, column/state types,
// and the FSM encoding used by the inverse substitution layer.
package ascon_aead128_pkg;

  typedef logic [4:0] ascon_col_t;
  // Index 4 holds x0 (bits 319:256), index 0 holds x4 (bits 63:0).
  typedef logic [4:0][63:0] ascon_state_t;

  localparam int unsigned ASCON_COLS = 32'd64;

  localparam ascon_col_t s_box [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam ascon_col_t inv_s_box [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  typedef enum logic [1:0] {
    ISB_IDLE = 2'd0,
    ISB_BUSY = 2'd1,
    ISB_DONE = 2'd2
  } isb_state_e;

  function automatic bit legal_cols(input int unsigned c);
    return (c == 32'd1) || (c == 32'd2) || (c == 32'd4) || (c == 32'd8) ||
           (c == 32'd16) || (c == 32'd32) || (c == 32'd64);
  endfunction

  // Slice counter width; a single slice still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned c);
    return ((ASCON_COLS / c) > 32'd1) ? $clog2(ASCON_COLS / c) : 32'd1;
  endfunction

endpackage

// File: rtl/inv_sbox_layer_if.sv
// Load/result handshake bundle of the inverse substitution layer.
interface inv_sbox_layer_if;
  import ascon_aead128_pkg::*;

  logic         in_valid;
  logic         in_ready;
  ascon_state_t in_state;
  logic         out_valid;
  logic         out_ready;
  ascon_state_t out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/inv_sbox_layer_inv_sbox.sv
// Single-column inverse Ascon S-box lookup, purely combinational.
module inv_sbox
  import ascon_aead128_pkg::*;
(
  input  ascon_col_t col_i,
  output ascon_col_t col_o
);

  assign col_o = inv_s_box[col_i];

endmodule

// File: rtl/inv_sbox_layer.sv
// Multi-cycle inverse Ascon substitution layer: a 320-bit state is captured,
// inverted COLS_PER_CYCLE columns at a time in place, then held until consumed.
module inv_sbox_layer
  import ascon_aead128_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 32'd8
) (
  input  logic            clk,
  input  logic            rst_n,
  inv_sbox_layer_if.slave bus
);

  localparam int unsigned SLICES = ASCON_COLS / COLS_PER_CYCLE;
  localparam int unsigned CNT_W  = cnt_width(COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 32'd1);

  if (!legal_cols(COLS_PER_CYCLE)) begin : g_bad_cols
    $error("inv_sbox_layer: COLS_PER_CYCLE must be 1, 2, 4, 8, 16, 32 or 64");
  end

  isb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  ascon_state_t     work_q;
  ascon_state_t     work_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [5:0]       base_s;
  logic [5:0]       col_idx_s [COLS_PER_CYCLE];
  ascon_col_t       col_in_s  [COLS_PER_CYCLE];
  ascon_col_t       col_out_s [COLS_PER_CYCLE];

  // Product never exceeds 63, so the truncation to 6 bits is exact.
  assign base_s = 6'(cnt_q) * 6'(COLS_PER_CYCLE);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx_s[g] = base_s + 6'(g);
    assign col_in_s[g]  = {work_q[4][col_idx_s[g]], work_q[3][col_idx_s[g]],
                           work_q[2][col_idx_s[g]], work_q[1][col_idx_s[g]],
                           work_q[0][col_idx_s[g]]};
    inv_sbox u_inv_sbox (
      .col_i (col_in_s[g]),
      .col_o (col_out_s[g])
    );
  end

  // Working register with the current slice of columns replaced.
  always_comb begin
    work_d = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      for (int w = 0; w < 5; w++) begin
        work_d[w][col_idx_s[g]] = col_out_s[g][w];
      end
    end
  end

  // Control FSM, slice counter, working register and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ISB_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ISB_IDLE: begin
          if (bus.in_valid) begin
            work_q     <= bus.in_state;
            cnt_q      <= '0;
            state_q    <= ISB_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ISB_BUSY: begin
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            state_q     <= ISB_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ISB_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ISB_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ISB_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_state = work_q;

endmodule

// File: tb/tb_inv_sbox_layer.sv
// Directed bench for inv_sbox_layer: fixed patterns, round-trips through an
// independent forward S-box, backpressure, mid-run reset and C = 1/8/64.
module tb_inv_sbox_layer;

  localparam logic [4:0] FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  inv_sbox_layer_if bus_m ();
  inv_sbox_layer_if bus_1 ();
  inv_sbox_layer_if bus_64 ();

  inv_sbox_layer #(.COLS_PER_CYCLE(8))  dut_m  (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  inv_sbox_layer #(.COLS_PER_CYCLE(1))  dut_1  (.clk(clk), .rst_n(rst_n), .bus(bus_1));
  inv_sbox_layer #(.COLS_PER_CYCLE(64)) dut_64 (.clk(clk), .rst_n(rst_n), .bus(bus_64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] get_col(input logic [319:0] s, input int j);
    return {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
  endfunction

  function automatic logic [319:0] put_col(input logic [319:0] s, input int j, input logic [4:0] c);
    logic [319:0] r;
    r = s;
    r[256+j] = c[4];
    r[192+j] = c[3];
    r[128+j] = c[2];
    r[64+j]  = c[1];
    r[j]     = c[0];
    return r;
  endfunction

  function automatic logic [319:0] fwd_layer(input logic [319:0] s);
    logic [319:0] r;
    r = s;
    for (int j = 0; j < 64; j++) r = put_col(r, j, FWD[get_col(s, j)]);
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Push one state through the C=8 instance; lat = 0 means out_valid never came.
  task automatic run_main(input logic [319:0] st, output logic [319:0] res, output int lat);
    lat = 0;
    res = '0;
    @(negedge clk);
    bus_m.in_valid = 1'b1;
    bus_m.in_state = st;
    @(posedge clk);
    #1;
    bus_m.in_valid = 1'b0;
    bus_m.in_state = rand_state();
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus_m.out_valid) begin
        lat = k;
        break;
      end
    end
    res = bus_m.out_state;
    bus_m.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_m.out_ready = 1'b0;
  endtask

  // Push one state through the C=1 and C=64 instances in parallel.
  task automatic run_sweep(input string tag, input logic [319:0] st, input logic [319:0] exp);
    int lat1;
    int lat64;
    lat1  = 0;
    lat64 = 0;
    @(negedge clk);
    bus_1.in_valid  = 1'b1;
    bus_1.in_state  = st;
    bus_64.in_valid = 1'b1;
    bus_64.in_state = st;
    @(posedge clk);
    #1;
    bus_1.in_valid  = 1'b0;
    bus_64.in_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (lat1 == 0 && bus_1.out_valid) lat1 = k;
      if (lat64 == 0 && bus_64.out_valid) lat64 = k;
      if (lat1 != 0 && lat64 != 0) break;
    end
    check({tag, "_lat_c1"},  320'(lat1),  320'(64));
    check({tag, "_lat_c64"}, 320'(lat64), 320'(1));
    check({tag, "_out_c1"},  bus_1.out_state,  exp);
    check({tag, "_out_c64"}, bus_64.out_state, exp);
    bus_1.out_ready  = 1'b1;
    bus_64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_1.out_ready  = 1'b0;
    bus_64.out_ready = 1'b0;
  endtask

  initial begin
    logic [319:0] st;
    logic [319:0] res;
    logic [319:0] zero_in;
    logic [319:0] ones_in;
    logic [319:0] ones_exp;
    int lat;

    zero_in = '0;
    zero_in[191:128] = '1;
    ones_in = '1;
    ones_exp = '0;
    ones_exp[127:64] = '1;

    rst_n = 1'b0;
    bus_m.in_valid   = 1'b0; bus_m.in_state  = '0; bus_m.out_ready  = 1'b0;
    bus_1.in_valid   = 1'b0; bus_1.in_state  = '0; bus_1.out_ready  = 1'b0;
    bus_64.in_valid  = 1'b0; bus_64.in_state = '0; bus_64.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  320'(bus_m.in_ready),  320'(1'b1));
    check("rst_out_valid", 320'(bus_m.out_valid), 320'(1'b0));
    check("rst_busy",      320'(bus_m.busy),      320'(1'b0));
    check("rst_out_state", bus_m.out_state,       320'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_main(zero_in, res, lat);
    check("zero_lat", 320'(lat), 320'(8));
    check("zero_out", res, 320'h0);
    run_main(ones_in, res, lat);
    check("ones_lat", 320'(lat), 320'(8));
    check("ones_out", res, ones_exp);

    run_sweep("zero", zero_in, 320'h0);
    run_sweep("ones", ones_in, ones_exp);

    for (int k = 0; k < 32; k++) begin
      st = '0;
      for (int j = 0; j < 64; j++) st = put_col(st, j, 5'((j + k) % 32));
      run_main(st, res, lat);
      check("rot_roundtrip", fwd_layer(res), st);
    end

    for (int n = 0; n < 1000; n++) begin
      st = rand_state();
      run_main(st, res, lat);
      check("rand_roundtrip", fwd_layer(res), st);
    end

    // Backpressure: result must hold while a second in_valid is ignored.
    @(negedge clk);
    bus_m.in_valid = 1'b1;
    bus_m.in_state = ones_in;
    @(posedge clk);
    #1;
    bus_m.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus_m.out_valid) begin
        lat = k;
        break;
      end
    end
    check("bp_lat", 320'(lat), 320'(8));
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bus_m.in_valid = 1'b1;
        bus_m.in_state = zero_in;
      end else begin
        bus_m.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_out_state", bus_m.out_state, ones_exp);
      check("bp_in_ready",  320'(bus_m.in_ready),  320'(1'b0));
      check("bp_out_valid", 320'(bus_m.out_valid), 320'(1'b1));
    end
    bus_m.in_valid = 1'b0;
    bus_m.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_m.out_ready = 1'b0;
    check("bp_drain_ready", 320'(bus_m.in_ready),  320'(1'b1));
    check("bp_drain_valid", 320'(bus_m.out_valid), 320'(1'b0));
    @(posedge clk);
    #1;
    check("bp_idle_busy", 320'(bus_m.busy), 320'(1'b0));

    // Reset asserted while the slice counter reads 3.
    @(negedge clk);
    bus_m.in_valid = 1'b1;
    bus_m.in_state = ones_in;
    @(posedge clk);
    #1;
    bus_m.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before", 320'(bus_m.busy), 320'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  320'(bus_m.in_ready),  320'(1'b1));
    check("mid_rst_out_valid", 320'(bus_m.out_valid), 320'(1'b0));
    check("mid_rst_busy",      320'(bus_m.busy),      320'(1'b0));
    check("mid_rst_out_state", bus_m.out_state,       320'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_main(zero_in, res, lat);
    check("post_rst_lat", 320'(lat), 320'(8));
    check("post_rst_out", res, 320'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sbox_layer.md
# inv_sbox_layer

Multi-cycle inverse substitution layer for the Ascon-AEAD128 core. It undoes the Ascon 5-bit S-box across all 64 columns of a 320-bit state. Columns are processed in configurable slices, so area can be traded against latency. It sits in the core's self-test and debug path: it recovers the pre-substitution state from a post-substitution state for round-trip checks of the forward substitution layer.

## Interface
- COLS_PER_CYCLE, default 8: columns inverted per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64; any other value is an elaboration error.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input state is valid.
- in_ready  output  1  block can accept a state.
- in_state  input  320  state words x0..x4; x0 = in_state[319:256], x4 = in_state[63:0].
- out_valid  output  1  result is held on out_state.
- out_ready  input  1  consumer accepts the result.
- out_state  output  320  inverse-substituted state, same word packing as in_state.
- busy  output  1  a state is loaded and not yet consumed.

## Operation
- Column j, for j in 0..63: bit4 = x0[j], bit3 = x1[j], bit2 = x2[j], bit1 = x3[j], bit0 = x4[j].
- Each output column is inv_s_box[column]. Table for indices 0..31, in hex: 14,1a,07,0d,00,09,0e,12,0a,06,1d,01,19,15,13,1e,18,16,0b,11,03,05,1c,1f,17,1b,04,08,0f,0c,10,02.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, capture in_state into the working register, clear the column counter and go to BUSY.
  - BUSY: each cycle, replace columns [cnt*C +: C] of the working register in place, where C = COLS_PER_CYCLE, then increment cnt. On the last slice (cnt = 64/C − 1), go to DONE.
  - DONE: out_valid = 1 and out_state = working register. On out_ready, go to IDLE.
- Counter width is clog2(64/C), with a minimum of 1 bit. The counter wraps to 0 on the last slice and is never read in IDLE or DONE.
- When C = 64, BUSY lasts exactly one cycle.
- in_ready is 0 in BUSY and DONE. in_valid in those states is ignored; no data is captured.
- in_state is only sampled on the accept cycle. Changes afterwards have no effect.
- busy = 1 in BUSY and DONE.

## Timing
- Reset, asynchronous: state = IDLE, cnt = 0, working register = 0.
- Outputs in reset: in_ready = 1, out_valid = 0, busy = 0, out_state = 0.
- Latency: the accept edge is edge 0, and out_valid rises after edge 64/C. With the default C = 8, out_valid is high 8 cycles after the accept cycle.
- Throughput: one state per 64/C + 2 cycles when out_ready is held high. The two extra cycles are the DONE cycle and the IDLE accept cycle. Back-to-back acceptance in the DONE→IDLE cycle is not supported.
- out_state is stable from the rise of out_valid through the cycle in which out_ready is sampled high. Holding out_ready low stalls indefinitely with no change to the output.
- rst_n asserted mid-BUSY or mid-DONE: the block returns to the reset state immediately and the partial result is discarded. The first in_valid after deassertion is accepted normally.
- All outputs are registered or decoded from FSM state only. No combinational path exists from in_valid or out_ready to any output.

## Structure
- Shared package ascon_aead128_pkg gains:
  - inv_s_box, the 32×5 constant table above, alongside the existing s_box;
  - a column typedef, logic [4:0];
  - a state typedef, five 64-bit words.
- Sub-module inv_sbox: purely combinational 5-bit lookup on inv_s_box, instantiated COLS_PER_CYCLE times by generate.
- Top level contains the FSM, the column counter and the 320-bit working register. Column extraction and insertion use the bit mapping above.

## Test plan
- All-zero check: in_state has x2 = all-ones and the other words 0. Required out_state = 320'h0, out_valid after 64/C cycles.
- All-ones check: in_state = 320'hF…F (every column 0x1F). Required out_state has x3 = all-ones and the other words 0.
- Exhaustive table check: load states whose columns step through 0..31 in a rotating pattern. Apply forward s_box to out_state and require it to equal in_state. Then run 1000 random states through the same round-trip.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid. Required: out_state stable, in_ready = 0, and a second in_valid ignored.
- Reset mid-operation: assert rst_n = 0 at cnt = 3. Required: same-cycle in_ready = 1, out_valid = 0, busy = 0. A new state then completes correctly.
- Parameter sweep: run the zero and ones checks for C = 1, 8 and 64. Required latency is 64, 8 and 1 cycles respectively.
